// File: rtl/logic_op_arb_pkg.sv
// Shared types and the bitwise operation used by the logic-op arbiter.
// Optional macro LOGIC_OP_ARB_ERR_EN: reserved opcode 7 yields zero instead of passing A through.
package logic_op_arb_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // One bit slice; the operation is purely bitwise so any width is built from this.
    function automatic logic apply_op(input op_e op, input logic a, input logic b);
        case (op)
            OP_AND:  apply_op = a & b;
            OP_OR:   apply_op = a | b;
            OP_NAND: apply_op = ~(a & b);
            OP_NOR:  apply_op = ~(a | b);
            OP_XOR:  apply_op = a ^ b;
            OP_XNOR: apply_op = ~(a ^ b);
            OP_NOT:  apply_op = ~a;
`ifdef LOGIC_OP_ARB_ERR_EN
            default: apply_op = 1'b0;
`else
            default: apply_op = a;
`endif
        endcase
    endfunction

endpackage

// File: rtl/logic_op_arbiter_unit.sv
// Combinational WIDTH-bit logic unit; err flags the reserved opcode when
// LOGIC_OP_ARB_ERR_EN is defined and is constant 0 otherwise.
module logic_op_unit
    import logic_op_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    always_comb begin
        result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            result[i] = apply_op(op_e'(op), a[i], b[i]);
        end
    end

`ifdef LOGIC_OP_ARB_ERR_EN
    assign err = (op_e'(op) == OP_RSVD);
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered logic unit among NUM_REQ requesters.
// Optional macro LOGIC_OP_ARB_ERR_EN enables the reserved-opcode error flag.
//
//   state | meaning
//   IDLE  | no response held; grant the next valid requester this cycle
//   BUSY  | response registered; wait for rsp_ready, no grants
module logic_op_arbiter
    import logic_op_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [3*NUM_REQ-1:0]         req_op,
    input  logic [WIDTH*NUM_REQ-1:0]     req_a,
    input  logic [WIDTH*NUM_REQ-1:0]     req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH-1:0]             rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [2:0]                   rsp_op,
    output logic                         rsp_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    logic              grant;
    logic [2:0]        win_op;
    logic [WIDTH-1:0]  win_a, win_b;
    logic [WIDTH-1:0]  unit_result;
    logic              unit_err;

    // Search upward from rr_ptr, wrapping at NUM_REQ (not a power of two in general).
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_op = req_op[3*i +: 3];
                win_a  = req_a[WIDTH*i +: WIDTH];
                win_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    logic_op_unit #(.WIDTH(WIDTH)) u_unit (
        .op     (win_op),
        .a      (win_a),
        .b      (win_b),
        .result (unit_result),
        .err    (unit_err)
    );

    // Grants are gated by rst_n so nothing is accepted while reset is asserted.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && win_found) begin
                    grant             = 1'b1;
                    req_ready[win_id] = 1'b1;
                    state_nxt         = BUSY;
                end
            end
            BUSY: begin
                if (rsp_valid && rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_op    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                rsp_valid <= 1'b1;
                rsp_data  <= unit_result;
                rsp_id    <= win_id;
                rsp_op    <= win_op;
                rsp_err   <= unit_err;
                rr_ptr    <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: vector table, scoreboard and
// hand-written reset / round-robin / backpressure sequences.
module tb_logic_op_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [11:0]  req_op;
    logic [31:0]  req_a;
    logic [31:0]  req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   rsp_data;
    logic [1:0]   rsp_id;
    logic [2:0]   rsp_op;
    logic         rsp_err;

    int n_pass  = 0;
    int n_total = 0;

    logic_op_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_op    (rsp_op),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
`ifdef LOGIC_OP_ARB_ERR_EN
            default: return 8'h00;
`else
            default: return a;
`endif
        endcase
    endfunction

    function automatic logic ref_err(input logic [2:0] op);
`ifdef LOGIC_OP_ARB_ERR_EN
        return op == 3'd7;
`else
        return (op != op);
`endif
    endfunction

    typedef struct packed {
        logic [1:0] id;
        logic [2:0] op;
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];

    // Scoreboard: push on each grant, pop on each response handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_rsp", 32'({rsp_id, rsp_op, rsp_err, rsp_data}), 32'(e));
                end
            end
            if (req_ready != 4'b0000) begin
                check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ready[i]) begin
                        e.id   = 2'(i);
                        e.op   = req_op[3*i +: 3];
                        e.err  = ref_err(req_op[3*i +: 3]);
                        e.data = ref_op(req_op[3*i +: 3], req_a[8*i +: 8], req_b[8*i +: 8]);
                        sb_q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*idx +: 3] = op;
        req_a[8*idx +: 8]  = a;
        req_b[8*idx +: 8]  = b;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        int         idx;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok;
        int gidx[$];
        int gcyc[$];
        logic [7:0] rsvd_data;
        logic       rsvd_err;

`ifdef LOGIC_OP_ARB_ERR_EN
        rsvd_data = 8'h00;
        rsvd_err  = 1'b1;
`else
        rsvd_data = 8'h5A;
        rsvd_err  = 1'b0;
`endif
        vecs[0] = '{2, 3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        vecs[1] = '{0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[2] = '{1, 3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0};
        vecs[3] = '{3, 3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[4] = '{0, 3'd3, 8'hF0, 8'h0C, 8'h03, 1'b0};
        vecs[5] = '{2, 3'd5, 8'hF0, 8'h3C, 8'h33, 1'b0};
        vecs[6] = '{1, 3'd6, 8'h5A, 8'hFF, 8'hA5, 1'b0};
        vecs[7] = '{3, 3'd7, 8'h5A, 8'h00, rsvd_data, rsvd_err};

        // Reset with every requester valid: no grants, outputs cleared.
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'd0, 8'hFF, 8'h0F);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'h0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check("rst_rsp_data", 32'(rsp_data), 32'h0);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'h0;
        @(negedge clk);
        check("rst_rsp_valid_after", 32'(rsp_valid), 32'h1);
        check("rst_rsp_data_after", 32'(rsp_data), 32'h0F);
        step();

        // Single-requester vectors, one op per entry.
        for (int v = 0; v < 8; v++) begin
            set_req(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b);
            req_valid = 4'(1 << vecs[v].idx);
            wait_grant(ok);
            check("vec_grant", 32'(req_ready), 32'(1 << vecs[v].idx));
            step();
            req_valid = 4'h0;
            @(negedge clk);
            check("vec_rsp_valid", 32'(rsp_valid), 32'h1);
            check("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].exp_data));
            check("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].idx));
            check("vec_rsp_op", 32'(rsp_op), 32'(vecs[v].op));
            check("vec_rsp_err", 32'(rsp_err), 32'(vecs[v].exp_err));
            step();
        end

        // Round-robin from rr_ptr=0 with all four valid.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'd2, 8'hFF, 8'h0F);
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gidx.push_back(i);
                gcyc.push_back(c);
            end
            if (c % 2 == 1) check("rr_rsp_data", 32'({rsp_valid, rsp_data}), 32'h1F0);
        end
        step();
        req_valid = 4'h0;
        check("rr_grant_count", 32'(gidx.size()), 32'd5);
        for (int k = 0; k < gidx.size() && k < 5; k++) begin
            check("rr_grant_idx", 32'(gidx[k]), 32'(k % 4));
            check("rr_grant_cycle", 32'(gcyc[k]), 32'(2 * k));
        end

        // Backpressure: held response, no grants, next grant right after the handshake.
        rsp_ready = 1'b0;
        set_req(1, 3'd4, 8'hAA, 8'h55);
        req_valid = 4'b0010;
        wait_grant(ok);
        check("bp_grant", 32'(req_ready), 32'b0010);
        step();
        set_req(2, 3'd0, 8'h0F, 8'h3C);
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold", 32'({rsp_valid, rsp_data, rsp_id, rsp_op}), 32'({1'b1, 8'hFF, 2'd1, 3'd4}));
            check("bp_no_ready", 32'(req_ready), 32'h0);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_still_valid", 32'(rsp_valid), 32'h1);
        step();
        @(negedge clk);
        check("bp_valid_drop", 32'(rsp_valid), 32'h0);
        check("bp_next_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'h0;
        @(negedge clk);
        check("bp_next_rsp", 32'({rsp_valid, rsp_data, rsp_id}), 32'({1'b1, 8'h0C, 2'd2}));
        step();

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        set_req(1, 3'd1, 8'h0F, 8'hF0);
        req_valid = 4'b0010;
        wait_grant(ok);
        check("mid_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'h0;
        @(negedge clk);
        check("mid_rsp_valid", 32'(rsp_valid), 32'h1);
        step();
        rst_n = 1'b0;
        set_req(3, 3'd5, 8'h11, 8'h22);
        req_valid = 4'b1010;
        @(negedge clk);
        check("mid_rst_no_grant", 32'(req_ready), 32'h0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_rsp_dropped", 32'(rsp_valid), 32'h0);
        check("mid_grant_req1", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'h0;
        @(negedge clk);
        check("mid_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 2'd1, 8'hFF}));
        step();
        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
